core_avalon_master: RTL and testbench

- Bridges the CPU core's simple word bus (addr/data_rd/data_wr/ready/write/start) onto the platform's Avalon-MM interconnect.
- Issues one Avalon transaction per core request.
- Handles waitrequest stalls and pipelined read responses; synchronizes the platform interrupt into the core clock domain.
- Sits between the arm810 core and the platform interconnect, in place of the bare master port.

---
 rtl/core_avalon_master.sv | 164 ++++++++++++++++
 tb/tb_core_avalon_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_avalon_master.sv
// core_avalon_master: bridges the core's single-word request bus onto an
// Avalon-MM master port. One Avalon transaction per core_start, with
// waitrequest stalls and pipelined read responses. avl_irq is level-synchronized
// into the clk domain.
// Optional build macro: CORE_AVALON_TIMEOUT_EN adds a response timeout and the
// bus_timeout output.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for core_start; request fields latched on start
//  READ_REQ  | avl_read asserted, waiting for waitrequest=0
//  WRITE_REQ | avl_write asserted, waiting for waitrequest=0
//  READ_WAIT | read accepted, waiting for readdatavalid
//  DONE      | core_ready pulse, back to IDLE next cycle
module core_avalon_master #(
    parameter int AVL_ADDR_W      = 32,
    parameter int IRQ_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [29:0]           core_addr,
    input  logic [31:0]           core_data_wr,
    input  logic                  core_write,
    input  logic                  core_start,
    output logic [31:0]           core_data_rd,
    output logic                  core_ready,
    output logic                  core_irq,
    output logic [AVL_ADDR_W-1:0] avl_address,
    output logic                  avl_read,
    output logic                  avl_write,
    output logic [31:0]           avl_writedata,
    output logic [3:0]            avl_byteenable,
    input  logic                  avl_waitrequest,
    input  logic [31:0]           avl_readdata,
    input  logic                  avl_readdatavalid,
`ifdef CORE_AVALON_TIMEOUT_EN
    output logic                  bus_timeout,
`endif
    input  logic                  avl_irq
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_REQ  = 3'd1,
        WRITE_REQ = 3'd2,
        READ_WAIT = 3'd3,
        DONE      = 3'd4
    } state_t;

    if (IRQ_SYNC_STAGES < 2 || IRQ_SYNC_STAGES > 4) begin : g_bad_irq_stages
        $error("IRQ_SYNC_STAGES must be within 2..4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit timeout counter");
    end

    state_t                     state_q, state_d;
    logic [29:0]                addr_q;
    logic [31:0]                wdata_q;
    logic [31:0]                rdata_q, rdata_d;
    logic [IRQ_SYNC_STAGES-1:0] irq_sync_q;
    logic                       rd_capture;
    logic                       wr_accept;
    logic                       tmo_hit;
    logic                       tmo_flag_d;

`ifdef CORE_AVALON_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        tmo_flag_q;

    assign tmo_hit = (state_q == READ_REQ || state_q == WRITE_REQ || state_q == READ_WAIT)
                     && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Timeout counter: zeroed on issue, counts every cycle a transaction is open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
            end else if (state_q != DONE) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            tmo_flag_q <= tmo_flag_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response arriving with the accepting cycle wins over a timeout.
    always_comb begin
        state_d    = state_q;
        rd_capture = avl_readdatavalid &&
                     ((state_q == READ_REQ && !avl_waitrequest) || state_q == READ_WAIT);
        wr_accept  = (state_q == WRITE_REQ) && !avl_waitrequest;
        tmo_flag_d = tmo_hit && !rd_capture && !wr_accept;
        case (state_q)
            IDLE:      if (core_start) state_d = core_write ? WRITE_REQ : READ_REQ;
            READ_REQ: begin
                if (rd_capture || tmo_hit) state_d = DONE;
                else if (!avl_waitrequest) state_d = READ_WAIT;
            end
            WRITE_REQ: if (wr_accept || tmo_hit) state_d = DONE;
            READ_WAIT: if (rd_capture || tmo_hit) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Read data only changes on read completion (real data or timeout marker).
    always_comb begin
        rdata_d = rdata_q;
        if (rd_capture) begin
            rdata_d = avl_readdata;
        end else if (tmo_flag_d && state_q != WRITE_REQ) begin
            rdata_d = 32'hDEAD_BEEF;
        end
    end

    // Request latch, read-data register and irq synchronizer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            irq_sync_q <= '0;
        end else begin
            if (state_q == IDLE && core_start) begin
                addr_q  <= core_addr;
                wdata_q <= core_data_wr;
            end
            rdata_q    <= rdata_d;
            irq_sync_q <= {irq_sync_q[IRQ_SYNC_STAGES-2:0], avl_irq};
        end
    end

    // Outputs decode from state so reset drops the strobes asynchronously.
    always_comb begin
        avl_read       = (state_q == READ_REQ);
        avl_write      = (state_q == WRITE_REQ);
        core_ready     = (state_q == DONE);
        avl_address    = AVL_ADDR_W'({addr_q, 2'b00});
        avl_writedata  = wdata_q;
        avl_byteenable = 4'hF;
        core_data_rd   = rdata_q;
        core_irq       = irq_sync_q[IRQ_SYNC_STAGES-1];
`ifdef CORE_AVALON_TIMEOUT_EN
        bus_timeout    = (state_q == DONE) && tmo_flag_q;
`endif
    end

endmodule

// File: tb/tb_core_avalon_master.sv
// Scoreboard bench for core_avalon_master: stimulus pushes expected Avalon
// transactions and expected read data; a negedge monitor pops and compares.
module tb_core_avalon_master;
    localparam int N_IRQ = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] core_addr = '0;
    logic [31:0] core_data_wr = '0;
    logic        core_write = 1'b0;
    logic        core_start = 1'b0;
    logic [31:0] core_data_rd;
    logic        core_ready;
    logic        core_irq;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest = 1'b0;
    logic [31:0] avl_readdata = '0;
    logic        avl_readdatavalid = 1'b0;
    logic        avl_irq = 1'b0;
`ifdef CORE_AVALON_TIMEOUT_EN
    logic        bus_timeout;
`endif

    always #5 clk = ~clk;

    core_avalon_master #(
        .AVL_ADDR_W     (32),
        .IRQ_SYNC_STAGES(N_IRQ),
`ifdef CORE_AVALON_TIMEOUT_EN
        .TIMEOUT_CYCLES (16)
`else
        .TIMEOUT_CYCLES (1024)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .core_addr        (core_addr),
        .core_data_wr     (core_data_wr),
        .core_write       (core_write),
        .core_start       (core_start),
        .core_data_rd     (core_data_rd),
        .core_ready       (core_ready),
        .core_irq         (core_irq),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
`ifdef CORE_AVALON_TIMEOUT_EN
        .bus_timeout      (bus_timeout),
`endif
        .avl_irq          (avl_irq)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } avl_txn_t;

    avl_txn_t    avl_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    avl_txn_t    m_txn;
    logic [31:0] m_exp;
    int          cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [29:0] a, input logic [31:0] d,
                             input bit expect_avl);
        core_start   = 1'b1;
        core_write   = we;
        core_addr    = a;
        core_data_wr = d;
        if (expect_avl) avl_q.push_back(avl_txn_t'{we, {a, 2'b00}, d});
    endtask

    // Monitor: compare every ready pulse and every accepted Avalon request.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_ready) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got ready=1 data=%h, required no pulse", core_data_rd);
                end else begin
                    m_exp = rd_q.pop_front();
                    check("ready_data_rd", core_data_rd, m_exp);
                end
            end
            if ((avl_read || avl_write) && !avl_waitrequest) begin
                if (avl_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_avl_txn: got rd=%0d wr=%0d addr=%h, required none",
                             avl_read, avl_write, avl_address);
                end else begin
                    m_txn = avl_q.pop_front();
                    check("avl_is_write", {31'd0, avl_write}, {31'd0, m_txn.we});
                    check("avl_address", avl_address, m_txn.addr);
                    check("avl_byteenable", {28'd0, avl_byteenable}, 32'hF);
                    if (m_txn.we) check("avl_writedata", avl_writedata, m_txn.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", core_ready, 0);
        check("rst_avl_read", avl_read, 0);
        check("rst_avl_write", avl_write, 0);
        check("rst_avl_address", avl_address, 0);
        check("rst_data_rd", core_data_rd, 0);
        check("rst_irq", core_irq, 0);
        rst = 1'b0;
        tick();

        // Zero-wait read, readdatavalid one cycle after acceptance.
        avl_waitrequest = 1'b0;
        start_req(1'b0, 30'h0000_0100, 32'h0, 1'b1);
        rd_q.push_back(32'hCAFE_F00D);
        tick();
        core_start = 1'b0;
        check("t1_read_issue", avl_read, 1);
        check("t1_address", avl_address, 32'h400);
        tick();
        check("t1_read_one_cycle", avl_read, 0);
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hCAFE_F00D;
        tick();
        avl_readdatavalid = 1'b0;
        avl_readdata      = '0;
        check("t1_ready_lat3", core_ready, 1);
        tick();
        check("t1_ready_one_cycle", core_ready, 0);

        // Write with five waitrequest cycles.
        avl_waitrequest = 1'b1;
        start_req(1'b1, 30'h3FFF_FFFF, 32'h1234_5678, 1'b1);
        rd_q.push_back(32'hCAFE_F00D);
        tick();
        core_start   = 1'b0;
        core_addr    = '0;
        core_data_wr = '0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) avl_waitrequest = 1'b0;
            check("t2_write_held", avl_write, 1);
            check("t2_addr_held", avl_address, 32'hFFFF_FFFC);
            check("t2_wdata_held", avl_writedata, 32'h1234_5678);
            tick();
        end
        check("t2_ready_after_accept", core_ready, 1);
        check("t2_write_dropped", avl_write, 0);
        tick();

        // Back-to-back write then read.
        start_req(1'b1, 30'h10, 32'hA5A5_A5A5, 1'b1);
        rd_q.push_back(32'hCAFE_F00D);
        tick();
        core_start = 1'b0;
        cnt = 1;
        while (!core_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        check("t3_write_lat2", cnt, 2);
        tick();
        start_req(1'b0, 30'h20, 32'h0, 1'b1);
        rd_q.push_back(32'h0BAD_F00D);
        tick();
        core_start = 1'b0;
        check("t3_read_issue_no_gap", avl_read, 1);
        tick();
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h0BAD_F00D;
        tick();
        avl_readdatavalid = 1'b0;
        check("t3_read_lat3", core_ready, 1);
        tick();

        // readdatavalid in the accepting cycle.
        start_req(1'b0, 30'h30, 32'h0, 1'b1);
        rd_q.push_back(32'h1357_9BDF);
        tick();
        core_start        = 1'b0;
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h1357_9BDF;
        tick();
        avl_readdatavalid = 1'b0;
        check("t4_same_cycle_ready", core_ready, 1);
        tick();

        // Stalled read, spurious start in READ_WAIT, readdatavalid while idle.
        avl_waitrequest = 1'b1;
        start_req(1'b0, 30'h2AAA_AAAA, 32'h0, 1'b1);
        rd_q.push_back(32'h89AB_CDEF);
        tick();
        core_start = 1'b0;
        tick();
        tick();
        avl_waitrequest = 1'b0;
        check("t5_read_held", avl_read, 1);
        check("t5_addr_held", avl_address, 32'hAAAA_AAA8);
        tick();
        avl_waitrequest = 1'b1;
        check("t5_read_dropped", avl_read, 0);
        start_req(1'b1, 30'h55, 32'h5555_5555, 1'b0);
        tick();
        core_start = 1'b0;
        check("t5_no_new_request", {31'd0, avl_read | avl_write}, 0);
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h89AB_CDEF;
        tick();
        avl_readdatavalid = 1'b0;
        check("t5_ready", core_ready, 1);
        tick();
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hDEAD_DEAD;
        tick();
        avl_readdatavalid = 1'b0;
        tick();
        check("t5_data_rd_hold", core_data_rd, 32'h89AB_CDEF);
        check("t5_no_extra_ready", core_ready, 0);

        // Reset while a read is stalled.
        start_req(1'b0, 30'h40, 32'h0, 1'b0);
        tick();
        core_start = 1'b0;
        check("t6_read_up", avl_read, 1);
        rst = 1'b1;
        #1;
        check("t6_async_read_drop", avl_read, 0);
        check("t6_data_rd_cleared", core_data_rd, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_idle_after_reset", avl_read, 0);
        avl_waitrequest   = 1'b0;
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hFFFF_0000;
        tick();
        avl_readdatavalid = 1'b0;
        tick();
        tick();
        check("t6_late_rdv_discarded", core_data_rd, 0);
        check("t6_no_ready", core_ready, 0);

        // irq synchronizer latency, rise and fall.
        check("irq_low_before", core_irq, 0);
        avl_irq = 1'b1;
        cnt = 0;
        while (!core_irq && cnt < 10) begin
            tick();
            cnt++;
        end
        check("irq_rise_latency", cnt, N_IRQ);
        avl_irq = 1'b0;
        cnt = 0;
        while (core_irq && cnt < 10) begin
            tick();
            cnt++;
        end
        check("irq_fall_latency", cnt, N_IRQ);

`ifdef CORE_AVALON_TIMEOUT_EN
        // Read that never gets a response.
        start_req(1'b0, 30'h50, 32'h0, 1'b1);
        rd_q.push_back(32'hDEAD_BEEF);
        tick();
        core_start = 1'b0;
        cnt = 0;
        while (!core_ready && cnt < 40) begin
            tick();
            cnt++;
        end
        check("tmo_latency", cnt, 16);
        check("tmo_bus_timeout", {31'd0, bus_timeout}, 1);
        tick();
        check("tmo_bus_timeout_pulse", {31'd0, bus_timeout}, 0);
`endif

        tick();
        tick();
        check("sb_rd_drained", rd_q.size(), 0);
        check("sb_avl_drained", avl_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
